// File: rtl/encoder_framer.sv
// Serial 32-bit payload in, Hamming(7,4)-encoded and interleaved 64-bit frame out, MSB first.
// Define ENCODER_FRAME_PARITY_EN to fill frame[63:56] with per-codeword even parity.
module encoder_framer (
    input  logic clk_encoder,
    input  logic rst_n,
    input  logic encoder_data_valid,
    input  logic data_encoder_in,
    output logic encoder_data_ready,
    output logic encoder_out_valid,
    output logic data_encoder_out,
    output logic encoder_frame_done
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [4:0] IN_LAST  = 5'd31;
    localparam logic [5:0] OUT_LAST = 6'd63;

    function automatic logic [6:0] hamming74(input logic [3:0] d);
        logic p1, p2, p4;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p4 = d[1] ^ d[2] ^ d[3];
        return {d[3], d[2], d[1], p4, d[0], p2, p1};
    endfunction

    // Bit m of every codeword lands in frame byte m, so a burst error in the
    // serial stream hits each codeword at most once per byte.
    function automatic logic [63:0] build_frame(input logic [31:0] pay);
        logic [63:0] f;
        logic [6:0]  cw;
        f = '0;
        for (int k = 0; k < 8; k++) begin
            cw = hamming74(pay[4*k +: 4]);
            for (int m = 0; m < 7; m++) begin
                f[8*m + k] = cw[m];
            end
`ifdef ENCODER_FRAME_PARITY_EN
            f[56 + k] = ^cw;
`endif
        end
        return f;
    endfunction

    logic [31:0] payload_q, payload_d;
    logic [4:0]  in_cnt_q,  in_cnt_d;
    logic        in_full_q, in_full_d;
    logic [0:0]  state_q,   state_d;
    logic [5:0]  out_cnt_q, out_cnt_d;
    logic [63:0] shift_q,   shift_d;

    logic accept;
    logic last_bit;
    logic load;

    assign accept   = encoder_data_valid && !in_full_q;
    assign last_bit = (state_q == ST_SEND) && (out_cnt_q == OUT_LAST);
    assign load     = in_full_q && ((state_q == ST_IDLE) || last_bit);

    // NOTE: every _d gets its hold value first so no path through this block
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        payload_d = payload_q;
        in_cnt_d  = in_cnt_q;
        in_full_d = in_full_q;
        state_d   = state_q;
        out_cnt_d = out_cnt_q;
        shift_d   = shift_q;

        // accept and load are mutually exclusive: one needs in_full low, the other high.
        if (accept) begin
            payload_d = {payload_q[30:0], data_encoder_in};
            in_cnt_d  = in_cnt_q + 5'd1;
            if (in_cnt_q == IN_LAST) begin
                in_full_d = 1'b1;
            end
        end

        if (load) begin
            shift_d   = build_frame(payload_q);
            out_cnt_d = '0;
            state_d   = ST_SEND;
            in_full_d = 1'b0;
        end else if (state_q == ST_SEND) begin
            shift_d   = {shift_q[62:0], 1'b0};
            out_cnt_d = out_cnt_q + 6'd1;
            if (last_bit) begin
                state_d = ST_IDLE;
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_encoder or negedge rst_n) begin
        if (!rst_n) begin
            payload_q <= '0;
            in_cnt_q  <= '0;
            in_full_q <= 1'b0;
            state_q   <= ST_IDLE;
            out_cnt_q <= '0;
            shift_q   <= '0;
        end else begin
            payload_q <= payload_d;
            in_cnt_q  <= in_cnt_d;
            in_full_q <= in_full_d;
            state_q   <= state_d;
            out_cnt_q <= out_cnt_d;
            shift_q   <= shift_d;
        end
    end

    assign encoder_data_ready = !in_full_q;
    assign encoder_out_valid  = (state_q == ST_SEND);
    assign data_encoder_out   = encoder_out_valid && shift_q[63];
    assign encoder_frame_done = last_bit;

endmodule

// File: tb/tb_encoder_framer.sv
// Directed bench for encoder_framer; expected frames are hand-computed constants
// for both builds of ENCODER_FRAME_PARITY_EN.
module tb_encoder_framer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic valid = 1'b0;
    logic din = 1'b0;
    logic ready, out_valid, dout, done;

    int passed = 0;
    int total  = 0;

    encoder_framer dut (
        .clk_encoder        (clk),
        .rst_n              (rst_n),
        .encoder_data_valid (valid),
        .data_encoder_in    (din),
        .encoder_data_ready (ready),
        .encoder_out_valid  (out_valid),
        .data_encoder_out   (dout),
        .encoder_frame_done (done)
    );

    always #5 clk = ~clk;

`ifdef ENCODER_FRAME_PARITY_EN
    localparam logic [63:0] F_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] F_ONE  = 64'h0100_0000_0001_0101;
    localparam logic [63:0] F_F0   = 64'h0202_0202_0202_0202;
`else
    localparam logic [63:0] F_ONES = 64'h00FF_FFFF_FFFF_FFFF;
    localparam logic [63:0] F_ONE  = 64'h0000_0000_0001_0101;
    localparam logic [63:0] F_F0   = 64'h0002_0202_0202_0202;
`endif
    localparam logic [63:0] F_ZERO = 64'h0;
    localparam logic [63:0] F_MSB  = 64'h0080_0000_8000_8080;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drives the top n payload bits MSB first; gap inserts an idle cycle with a
    // misleading data bit before each valid cycle.
    task automatic send_bits(input logic [31:0] p, input int n, input bit gap);
        int guard;
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                @(negedge clk);
                valid = 1'b0;
                din   = ~p[31-i];
            end
            @(negedge clk);
            valid = 1'b1;
            din   = p[31-i];
            guard = 0;
            while (!ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) check("send_timeout", 64'd0, 64'd1);
        end
        @(negedge clk);
        valid = 1'b0;
        din   = 1'b0;
    endtask

    task automatic recv(output logic [63:0] f, output int wait_cyc, output int rdy_low,
                        output int errs);
        f = '0;
        wait_cyc = 0;
        rdy_low = 0;
        errs = 0;
        @(negedge clk);
        while (!out_valid && wait_cyc < 300) begin
            @(negedge clk);
            wait_cyc++;
        end
        for (int i = 0; i < 64; i++) begin
            if (i > 0) @(negedge clk);
            f[63-i] = dout;
            if (out_valid !== 1'b1) errs++;
            if (done !== (i == 63)) errs++;
            if (ready !== 1'b1) rdy_low++;
        end
    endtask

    task automatic run_single(input string tag, input logic [31:0] p,
                              input logic [63:0] exp, input bit gap);
        logic [63:0] f;
        int w, rl, e;
        send_bits(p, 32, gap);
        check({tag, "_hold_ready"}, {63'd0, ready}, 64'd0);
        check({tag, "_pre_valid"}, {63'd0, out_valid}, 64'd0);
        recv(f, w, rl, e);
        check({tag, "_frame"}, f, exp);
        check({tag, "_latency"}, 64'(w), 64'd0);
        check({tag, "_valid_done"}, 64'(e), 64'd0);
        check({tag, "_ready_in_frame"}, 64'(rl), 64'd0);
        @(negedge clk);
        check({tag, "_idle_after"}, {62'd0, out_valid, dout}, 64'd0);
    endtask

    logic [63:0] f1, f2;
    int w1, w2, rl1, rl2, e1, e2;

    initial begin
        #2;
        check("rst_outputs", {60'd0, ready, out_valid, dout, done}, 64'h8);
        @(negedge clk);
        rst_n = 1'b1;

        run_single("zero", 32'h0000_0000, F_ZERO, 1'b0);
        run_single("ones", 32'hFFFF_FFFF, F_ONES, 1'b0);
        run_single("one",  32'h0000_0001, F_ONE,  1'b0);
        run_single("msb",  32'h8000_0000, F_MSB,  1'b0);
        run_single("gap",  32'h0000_00F0, F_F0,   1'b1);

        // Second payload arrives during the first frame: ready must stay low for
        // the last 32 bits of frame 1, and frame 2 follows without a gap.
        fork
            begin
                send_bits(32'h0000_0001, 32, 1'b0);
                send_bits(32'h8000_0000, 32, 1'b0);
            end
            begin
                recv(f1, w1, rl1, e1);
                recv(f2, w2, rl2, e2);
            end
        join
        check("b2b_frame1", f1, F_ONE);
        check("b2b_frame2", f2, F_MSB);
        check("b2b_ready_low", 64'(rl1), 64'd32);
        check("b2b_no_gap", 64'(w2), 64'd0);
        check("b2b_valid_done", 64'(e1 + e2), 64'd0);
        check("b2b_ready_frame2", 64'(rl2), 64'd0);
        @(negedge clk);
        check("b2b_idle_after", {63'd0, out_valid}, 64'd0);

        // Partial payload discarded by reset.
        send_bits(32'hFFFF_FFFF, 17, 1'b0);
        #2 rst_n = 1'b0;
        #1 check("partial_rst_outputs", {60'd0, ready, out_valid, dout, done}, 64'h8);
        @(negedge clk);
        rst_n = 1'b1;
        run_single("fresh", 32'h8000_0000, F_MSB, 1'b0);

        // Reset in the middle of a frame clears the output path asynchronously.
        send_bits(32'hFFFF_FFFF, 32, 1'b0);
        repeat (12) @(negedge clk);
        check("mid_frame_bit", {62'd0, out_valid, dout}, 64'h3);
        #2 rst_n = 1'b0;
        #1 check("mid_rst_outputs", {60'd0, ready, out_valid, dout, done}, 64'h8);
        @(negedge clk);
        rst_n = 1'b1;
        run_single("post_rst", 32'h0000_0001, F_ONE, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
